// File: rtl/boot_frame_loader_if.sv
// rtl/boot_frame_loader_if.sv - UART FIFO read port and instruction-memory write port of the boot loader
interface boot_frame_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [7:0]            fifo_rd_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  fifo_empty, fifo_rd_data,
    output fifo_rd_en, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output fifo_empty, fifo_rd_data,
    input  fifo_rd_en, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_frame_loader.sv
// rtl/boot_frame_loader.sv - boot frame parser loading LE words into imem; holds the CPU in reset until done
// Define BOOT_CHECKSUM_EN to require a trailing CSUM byte (8-bit sum of LEN_LO, LEN_HI and data).
module boot_frame_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  boot_frame_loader_if.master bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam logic [16:0]           MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    SYNC,
    LEN0,
    LEN1,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                state, state_n;
  logic                  pending;
  logic [7:0]            len_lo;
  logic [15:0]           count;
  logic [15:0]           words_left;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [23:0]           shift;

  assign count = {bus.fifo_rd_data, len_lo};

  // One pop in flight at a time: the popped byte is valid while pending is high.
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && !pending && (state != DONE) && (state != ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SYNC;
      cpu_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      cpu_rst <= (state_n != DONE);
      busy    <= !(state_n inside {SYNC, DONE, ERR});
      done    <= (state_n == DONE);
      error   <= (state_n == ERR);
    end
  end

  always_comb begin
    state_n = state;
    if (pending) begin
      case (state)
        SYNC: if (bus.fifo_rd_data == 8'hA5) state_n = LEN0;
        LEN0: state_n = LEN1;
        LEN1: begin
          if ({1'b0, count} > MAX_WORDS) state_n = ERR;
          else if (count == 16'd0)       state_n = AFTER_DATA;
          else                           state_n = DATA;
        end
        DATA: if (byte_idx == 2'd3 && words_left == 16'd1) state_n = AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
        CSUM: state_n = (bus.fifo_rd_data == csum) ? DONE : ERR;
`endif
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= 1'b0;
      len_lo         <= '0;
      words_left     <= '0;
      byte_idx       <= '0;
      word_idx       <= '0;
      shift          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      pending     <= bus.fifo_rd_en;
      bus.imem_we <= 1'b0;
      if (pending) begin
        case (state)
          LEN0: len_lo <= bus.fifo_rd_data;
          LEN1: words_left <= count;
          DATA: begin
            // Bytes enter at the top so the first byte ends up least significant.
            byte_idx <= byte_idx + 2'd1;
            shift    <= {bus.fifo_rd_data, shift[23:8]};
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= BASE + word_idx;
              bus.imem_wdata <= {bus.fifo_rd_data, shift};
              word_idx       <= word_idx + ADDR_WIDTH'(1);
              words_left     <= words_left - 16'd1;
            end
          end
          default: ;
        endcase
`ifdef BOOT_CHECKSUM_EN
        if (state == LEN0)                 csum <= bus.fifo_rd_data;
        else if (state inside {LEN1, DATA}) csum <= csum + bus.fifo_rd_data;
`endif
      end
    end
  end
endmodule

// File: doc/boot_frame_loader.md
# boot_frame_loader

Bootloader frame parser on the CPU side of the UART receive FIFO. It pops bytes from the FIFO read port, finds a sync byte, decodes a little-endian word count, and assembles little-endian 32-bit words. It writes those words into instruction memory and holds the CPU in reset until a complete, valid image has been loaded.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width; max image = 2**ADDR_WIDTH words
- BASE_ADDR, 0, word address of the first loaded word
- clk  input  1  CPU clock; the only clock
- rst  input  1  asynchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag (CPU domain)
- fifo_rd_en  output  1  FIFO pop request
- fifo_rd_data  input  8  FIFO read data, registered, valid the cycle after a pop
- imem_we  output  1  one-cycle instruction-memory write strobe
- imem_addr  output  ADDR_WIDTH  word address
- imem_wdata  output  32  assembled word
- cpu_rst  output  1  holds the CPU in reset; high until done
- busy  output  1  frame reception in progress (past sync, not done or error)
- done  output  1  sticky; image loaded and accepted
- error  output  1  sticky; frame rejected

## Operation
- Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count), LEN×4 data bytes with least significant byte first, then CSUM (only with the macro enabled).
- FSM states: SYNC → LEN0 → LEN1 → DATA → CSUM → DONE; any state can go to ERR.
- SYNC: discard bytes until 0xA5 is seen, then go to LEN0.
- LEN0, LEN1: latch the 16-bit count.
  - count > 2**ADDR_WIDTH: go to ERR.
  - count = 0: go to CSUM, or to DONE with the macro disabled.
  - otherwise: go to DATA.
- DATA: a 2-bit byte index shifts bytes into the word, least significant byte first.
  - On the 4th byte: pulse imem_we, with imem_addr = BASE_ADDR + word_idx (ADDR_WIDTH bits, truncating).
  - word_idx increments after each write.
  - After word LEN-1: go to CSUM, or to DONE with the macro disabled.
- DONE and ERR are terminal until rst. No further pops occur in either state.
- In DONE, cpu_rst=0. In ERR, cpu_rst stays 1.
- Reset values:
  - fifo_rd_en=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_rst=1, busy=0, done=0, error=0
  - state=SYNC; all counters cleared
- Reset mid-frame: the partial word is discarded and no write is issued. The next frame loads from BASE_ADDR again.

## Timing
- Pop handshake: at most one pop is outstanding.
  - fifo_rd_en is high in cycle N only if fifo_empty=0 in N, no pop is pending, and the state is not DONE or ERR.
  - The byte is consumed in cycle N+1, and fifo_rd_en is 0 in N+1.
  - The earliest next pop is N+2, giving a peak rate of 1 byte per 2 clocks.
- The FIFO empty flag is honoured; the block never pops while fifo_empty=1.
- The write for a word asserts imem_we, imem_addr and imem_wdata in cycle N+2, where N is the pop of the word's 4th byte. All three are stable for that one cycle.
- done/cpu_rst change in the cycle after the terminal byte is consumed.
  - The terminal byte is CSUM, or the last data byte with the macro disabled.
  - When the terminal byte is a data byte, the change is in the same cycle as the final imem_we.
- error is asserted in the cycle after the offending byte is consumed.
- busy is high from the cycle after the sync byte is consumed until done or error.
- All outputs except fifo_rd_en are registered.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - A CSUM byte follows the data. It must equal the 8-bit sum mod 256 of LEN_LO, LEN_HI and all data bytes.
  - On a match, go to DONE. On a mismatch, go to ERR.
  - All words have already been written when the check happens; cpu_rst stays 1 on a mismatch.
- BOOT_CHECKSUM_EN undefined:
  - No CSUM state and no checksum accumulator.
  - DONE follows the last data byte directly.

## Test plan
- Bytes A5 01 00 EF BE AD DE 39 (macro on) → one imem_we, addr 0, data 0xDEADBEEF; then done=1, cpu_rst=0, error=0.
- Bytes 00 FF 5A, then the frame above → the three leading bytes are popped and discarded; same single write and done.
- Same frame with CSUM 0x38 → write at addr 0 occurs; then error=1, done=0, cpu_rst=1; no further pops.
- Bytes A5 00 00 00 (macro on) → zero writes; done=1. Macro off: A5 00 00 → done=1.
- ADDR_WIDTH=4, bytes A5 11 00 → error=1 after the LEN_HI byte; zero writes.
- rst pulsed after 6 of 8 data bytes of a 2-word frame → all outputs at reset values; a resent full frame writes addr 0 and 1 and reaches done. FIFO held empty for 20 cycles mid-frame → fifo_rd_en stays 0 and the load resumes correctly.
